// File: rtl/div_arb_pkg.sv
// Shared types and helpers for the divider arbiter.
// Holds the FSM state encoding, the error quotient pattern and the
// round-robin pick function used by rr_arbiter.
package div_arb_pkg;

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, RESP} arb_state_t;

    // Largest supported requester count; the pick function works on this width.
    localparam int MAX_REQ = 8;

    // Quotient returned on timeout or divide-by-zero; sliced to W at the user.
    localparam logic [63:0] DIV_ERR_Q = '1;

    // First set bit of valid searching upward from ptr, wrapping at n.
    // Returns 0 when nothing is set; callers qualify with |valid.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                           input logic [2:0]         ptr,
                                           input int unsigned        n);
        int unsigned j;
        logic        found;
        rr_pick = 3'd0;
        found   = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            j = (32'(ptr) + k) % n;
            if (k < n && !found && valid[j]) begin
                rr_pick = 3'(j);
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/div_arbiter_rr_arbiter.sv
// Combinational round-robin picker: request vector plus priority pointer in,
// one-hot grant plus winner index out.
module rr_arbiter
    import div_arb_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic [MAX_REQ-1:0] req_ext;
    logic [2:0]         ptr_ext;
    logic [2:0]         pick;

    // Widen to the package function's fixed width and pick the winner
    always_comb begin
        req_ext           = '0;
        req_ext[NREQ-1:0] = req;
        ptr_ext           = '0;
        ptr_ext[IW-1:0]   = ptr;
        pick              = rr_pick(req_ext, ptr_ext, NREQ);
        idx               = pick[IW-1:0];
        any               = |req;
        grant             = any ? (NREQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one sequential divider between NREQ requesters.
// Round-robin grant, operand capture, divider reset/start sequencing with a
// timeout guard, and a one-cycle response pulse back to the winner.
// Optional macro DIV_ZERO_BYPASS_EN: a zero denominator skips the divider and
// answers with the error quotient on the next cycle.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int W       = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_num,
    input  logic [NREQ*W-1:0] req_den,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_q,
    output logic              rsp_err,
    output logic              div_rst,
    output logic              div_start,
    output logic [W-1:0]      div_num,
    output logic [W-1:0]      div_den,
    input  logic [W-1:0]      div_q,
    input  logic              div_done,
    output logic              busy
);

    localparam int             IW       = $clog2(NREQ);
    localparam int             CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  TMO_LAST = CW'(TIMEOUT - 1);
    localparam logic [W-1:0]   ERR_Q    = DIV_ERR_Q[W-1:0];

    arb_state_t      state, state_next;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   winner;
    logic [CW-1:0]   cnt;

    logic [NREQ-1:0] grant;
    logic [IW-1:0]   pick_idx;
    logic            any_req;
    logic [W-1:0]    num_sel;
    logic [W-1:0]    den_sel;
    logic            done_ok;
    logic            tmo;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (pick_idx),
        .any   (any_req)
    );

    // Operand mux for the current winner
    always_comb begin
        num_sel = '0;
        den_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IW'(i)) begin
                num_sel = req_num[i*W +: W];
                den_sel = req_den[i*W +: W];
            end
        end
    end

    // A done seen on the first RUN cycle may be left over from the last op
    assign done_ok = (state == RUN) && (cnt != '0) && div_done;
    assign tmo     = (state == RUN) && (cnt == TMO_LAST);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (any_req) begin
`ifdef DIV_ZERO_BYPASS_EN
                    state_next = (den_sel == '0) ? RESP : CLEAR;
`else
                    state_next = CLEAR;
`endif
                end
            end
            CLEAR:   state_next = RUN;
            RUN:     if (done_ok || tmo) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, timeout counter, result latch and pointer advance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr  <= '0;
            winner  <= '0;
            cnt     <= '0;
            div_num <= '0;
            div_den <= '0;
            rsp_q   <= '0;
            rsp_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        winner  <= pick_idx;
                        div_num <= num_sel;
                        div_den <= den_sel;
                        cnt     <= '0;
`ifdef DIV_ZERO_BYPASS_EN
                        if (den_sel == '0) begin
                            rsp_q   <= ERR_Q;
                            rsp_err <= 1'b1;
                        end
`endif
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    // done takes priority over a simultaneous timeout
                    if (done_ok) begin
                        rsp_q   <= div_q;
                        rsp_err <= 1'b0;
                    end else if (tmo) begin
                        rsp_q   <= ERR_Q;
                        rsp_err <= 1'b1;
                    end
                end
                RESP: begin
                    rr_ptr <= (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; grants are suppressed while reset is held
    always_comb begin
        req_ready = (reset && state == IDLE) ? grant : '0;
        rsp_valid = (state == RESP) ? (NREQ'(1) << winner) : '0;
        div_rst   = !reset || (state == CLEAR);
        div_start = (state == RUN);
        busy      = (state != IDLE);
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter with a behavioural divider model.
module tb_div_arbiter;

    localparam int NREQ    = 4;
    localparam int W       = 16;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_num;
    logic [NREQ*W-1:0] req_den;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_q;
    logic              rsp_err;
    logic              div_rst;
    logic              div_start;
    logic [W-1:0]      div_num;
    logic [W-1:0]      div_den;
    logic [W-1:0]      div_q;
    logic              div_done;
    logic              busy;

    div_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_num   (req_num),
        .req_den   (req_den),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_q     (rsp_q),
        .rsp_err   (rsp_err),
        .div_rst   (div_rst),
        .div_start (div_start),
        .div_num   (div_num),
        .div_den   (div_den),
        .div_q     (div_q),
        .div_done  (div_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Divider model: done rises after lat cycles of start; hung never finishes;
    // sticky keeps done high across div_rst until the next start is seen.
    int         lat    = 18;
    bit         hung   = 1'b0;
    bit         sticky = 1'b0;
    int         dcnt   = 0;
    logic       mdone  = 1'b0;
    logic [W-1:0] mq   = '0;
    assign div_q    = mq;
    assign div_done = mdone;

    always @(posedge clk) begin
        if (div_rst) begin
            dcnt <= 0;
            if (!sticky) mdone <= 1'b0;
        end else if (div_start) begin
            if (dcnt == 0) mdone <= 1'b0;
            if (!hung && dcnt == lat - 1) begin
                mdone <= 1'b1;
                mq    <= (div_den == '0) ? '1 : div_num / div_den;
            end
            if (dcnt < lat) dcnt <= dcnt + 1;
        end
    end

    int vec = 0;
    int bad = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #2;
    endtask

    task automatic set_req(input int i, input logic v, input logic [W-1:0] n, input logic [W-1:0] d);
        req_valid[i]       = v;
        req_num[i*W +: W]  = n;
        req_den[i*W +: W]  = d;
    endtask

    // Round-robin expectation: first valid requester at or after p, wrapping
    function automatic int exp_pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    // Wait (bounded) for the response of a grant made in cycle g, check it,
    // then step into the following IDLE cycle.
    task automatic wait_rsp(input string nm, input int idx, input logic [W-1:0] eq,
                            input logic eerr, input int elat, input int g);
        bit got = 1'b0;
        while (!got && cyc - g < 200) begin
            if (rsp_valid != '0) got = 1'b1;
            else step();
        end
        chk({nm, "_seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({nm, "_vld"}, 32'(rsp_valid), 32'(1) << idx);
            chk({nm, "_q"},   32'(rsp_q),     32'(eq));
            chk({nm, "_err"}, 32'(rsp_err),   32'(eerr));
            chk({nm, "_lat"}, 32'(cyc - g),   32'(elat));
        end
        step();
    endtask

    task automatic do_op(input string nm, input int idx, input logic [W-1:0] n,
                         input logic [W-1:0] d, input logic [W-1:0] eq,
                         input logic eerr, input int elat);
        int g;
        set_req(idx, 1'b1, n, d);
        #1;
        chk({nm, "_ready"}, 32'(req_ready), 32'(1) << idx);
        g = cyc;
        step();
        // scramble operands: the arbiter must not reread them
        set_req(idx, 1'b0, ~n, ~d);
        wait_rsp(nm, idx, eq, eerr, elat, g);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    typedef struct {
        int           idx;
        logic [W-1:0] n;
        logic [W-1:0] d;
        logic [W-1:0] q;
    } vec_t;

    initial begin
        vec_t         tbl[6];
        logic [W-1:0] q4[4];
        int           g;

        tbl[0] = '{2, 16'hFFFF, 16'h0001, 16'hFFFF};
        tbl[1] = '{1, 16'd5,    16'd7,    16'd0};
        tbl[2] = '{3, 16'd0,    16'd3,    16'd0};
        tbl[3] = '{0, 16'hFFFF, 16'hFFFF, 16'd1};
        tbl[4] = '{2, 16'd1000, 16'd3,    16'd333};
        tbl[5] = '{1, 16'h8000, 16'd2,    16'h4000};
        q4 = '{16'd333, 16'd500, 16'd600, 16'd666};

        req_valid = '0;
        req_num   = '0;
        req_den   = '0;
        reset     = 1'b0;

        // Reset values, with requests present to show no grant leaks out
        step();
        req_valid = 4'b0101;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp",   32'(rsp_valid), 32'd0);
        chk("rst_q",     32'(rsp_q),     32'd0);
        chk("rst_err",   32'(rsp_err),   32'd0);
        chk("rst_divrst", 32'(div_rst),  32'd1);
        chk("rst_start", 32'(div_start), 32'd0);
        chk("rst_opnd",  {div_num, div_den}, 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        req_valid = '0;
        step();
        reset = 1'b1;
        #1;
        chk("rel_divrst", 32'(div_rst), 32'd0);
        step();

        // Single request, 18-cycle divider: grant g, CLEAR g+1, response g+21
        do_op("single", 0, 16'h0300, 16'h0010, 16'h0030, 1'b0, lat + 3);

        // Table of single requests covering operand boundaries
        for (int i = 0; i < 6; i++)
            do_op($sformatf("tbl%0d", i), tbl[i].idx, tbl[i].n, tbl[i].d, tbl[i].q, 1'b0, lat + 3);

        // Stale done left high from the previous op must not finish the next
        sticky = 1'b1;
        do_op("stale_a", 1, 16'd100, 16'd7,  16'd14, 1'b0, lat + 3);
        do_op("stale_b", 1, 16'd900, 16'd30, 16'd30, 1'b0, lat + 3);
        sticky = 1'b0;

        // Hung divider: timeout answer, then normal service resumes
        hung = 1'b1;
        do_op("hung", 3, 16'd1234, 16'd5, 16'hFFFF, 1'b1, TIMEOUT + 2);
        hung = 1'b0;
        do_op("after_hung", 3, 16'd1234, 16'd5, 16'd246, 1'b0, lat + 3);

        // Zero denominator
        set_req(1, 1'b1, 16'd77, 16'd0);
        #1;
        chk("dz_ready", 32'(req_ready), 32'd2);
        g = cyc;
        step();
        set_req(1, 1'b0, 16'd0, 16'd1);
`ifdef DIV_ZERO_BYPASS_EN
        chk("dz_nostart", 32'(div_start), 32'd0);
        chk("dz_norst",   32'(div_rst),   32'd0);
        wait_rsp("dz", 1, 16'hFFFF, 1'b1, 1, g);
`else
        chk("dz_clear", 32'(div_rst), 32'd1);
        step();
        chk("dz_start", 32'(div_start), 32'd1);
        wait_rsp("dz", 1, 16'hFFFF, 1'b0, lat + 3, g);
`endif

        // All four held high: grants 0,1,2,3 then wrap to 0
        do_reset();
        for (int i = 0; i < NREQ; i++)
            set_req(i, 1'b1, W'((i + 1) * 1000), W'(i + 3));
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("all4_ready%0d", k), 32'(req_ready), 32'(1) << (k % 4));
            g = cyc;
            step();
            wait_rsp($sformatf("all4_%0d", k), k % 4, q4[k % 4], 1'b0, lat + 3, g);
        end
        req_valid = '0;
        step();

        // Reset mid-RUN with req 2 still pending
        set_req(2, 1'b1, 16'd5000, 16'd7);
        #1;
        chk("mid_ready", 32'(req_ready), 32'd4);
        step();
        step();
        step();
        chk("mid_inrun", 32'(div_start), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_busy",  32'(busy),      32'd0);
        chk("mid_divrst", 32'(div_rst),  32'd1);
        chk("mid_start", 32'(div_start), 32'd0);
        chk("mid_ready0", 32'(req_ready), 32'd0);
        chk("mid_opnd",  {div_num, div_den}, 32'd0);
        chk("mid_rsp",   {16'(rsp_valid), rsp_q}, 32'd0);
        step();
        chk("mid_rsp2",  32'(rsp_valid), 32'd0);
        reset = 1'b1;
        #1;
        chk("mid_regrant", 32'(req_ready), 32'd4);
        g = cyc;
        step();
        set_req(2, 1'b0, 16'd0, 16'd1);
        wait_rsp("mid_op", 2, 16'd714, 1'b0, lat + 3, g);

        // Randomized traffic against a queue-free scoreboard
        begin
            logic [NREQ-1:0] rv;
            logic [W-1:0]    rn[NREQ];
            logic [W-1:0]    rd[NREQ];
            int              m_ptr, m_w, m_g, w, c;
            bit              m_busy;
            logic [W-1:0]    m_q;

            lat = 4;
            do_reset();
            rv = '0; m_ptr = 0; m_busy = 1'b0; m_w = 0; m_g = 0; m_q = '0;
            for (int i = 0; i < NREQ; i++) begin rn[i] = '0; rd[i] = 16'd1; end
            c = 0;
            while ((c < 500 || m_busy) && c < 700) begin
                if (c < 500) begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (!rv[i] && $urandom_range(0, 2) == 0) begin
                            rv[i] = 1'b1;
                            rn[i] = W'($urandom);
                            rd[i] = ($urandom_range(0, 1) == 0) ? W'($urandom_range(1, 300))
                                                                 : W'($urandom_range(1, 65535));
                        end
                    end
                end else begin
                    rv = '0;
                end
                for (int i = 0; i < NREQ; i++) set_req(i, rv[i], rn[i], rd[i]);
                #1;
                if (!m_busy) begin
                    w = exp_pick(rv, m_ptr);
                    chk("rand_ready", 32'(req_ready), (w < 0) ? 32'd0 : (32'(1) << w));
                    if (w >= 0) begin
                        m_busy = 1'b1;
                        m_w    = w;
                        m_q    = rn[w] / rd[w];
                        m_g    = cyc;
                        if ($urandom_range(0, 1) == 0) begin
                            rv[w] = 1'b0;
                        end else begin
                            rn[w] = W'($urandom);
                            rd[w] = W'($urandom_range(1, 65535));
                        end
                    end
                end else begin
                    chk("rand_noready", 32'(req_ready), 32'd0);
                    if (rsp_valid != '0 || cyc >= m_g + lat + 3) begin
                        chk("rand_vld", 32'(rsp_valid), 32'(1) << m_w);
                        chk("rand_q",   32'(rsp_q),     32'(m_q));
                        chk("rand_err", 32'(rsp_err),   32'd0);
                        chk("rand_lat", 32'(cyc - m_g), 32'(lat + 3));
                        m_ptr  = (m_w + 1) % NREQ;
                        m_busy = 1'b0;
                    end
                end
                step();
                c++;
            end
            chk("rand_drained", 32'(m_busy), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, got cycle %0d expected completion", cyc);
        $fatal(1);
    end

endmodule
